// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding select codes, MD sequencer state encoding and a register-hit helper.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } mdState_t;

    // A producer only counts when it writes the RF and is not targeting $0.
    function automatic logic regHit(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// Mult/div occupancy sequencer: tracks how long the MD unit is busy and pulses mdDone.
//  state   | meaning
//  MD_IDLE | unit free
//  MD_BUSY | op in flight, cnt counts down to terminal 0
//  MD_DONE | last cycle, HI/LO written at end of this cycle
module hazard_ctrl_md_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic mdStartE,
    input  logic mdIsDivE,
    output logic mdBusy,
    output logic mdDone
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    mdState_t         state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] loadVal;

    assign loadVal = mdIsDivE ? DIV_LOAD : MUL_LOAD;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            mdBusy <= 1'b0;
            mdDone <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (mdStartE) begin
                        state  <= MD_BUSY;
                        cnt    <= loadVal;
                        mdBusy <= 1'b1;
                    end
                end
                // A start request while busy cannot legally happen; it is ignored.
                MD_BUSY: begin
                    if (cnt == '0) begin
                        state  <= MD_DONE;
                        mdDone <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                MD_DONE: begin
                    mdDone <= 1'b0;
                    if (mdStartE) begin
                        state <= MD_BUSY;
                        cnt   <= loadVal;
                    end else begin
                        state  <= MD_IDLE;
                        mdBusy <= 1'b0;
                    end
                end
                default: begin
                    state  <= MD_IDLE;
                    cnt    <= '0;
                    mdBusy <= 1'b0;
                    mdDone <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: stalls, flushes, forwarding and MD scheduling.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       branchD,
    input  logic       takenD,
    input  logic       mdReadD,
    input  logic       mdOpD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeRegE,
    input  logic       regWriteE,
    input  logic       memToRegE,
    input  logic       mdStartE,
    input  logic       mdIsDivE,
    input  logic [4:0] writeRegM,
    input  logic       regWriteM,
    input  logic       memToRegM,
    input  logic [4:0] writeRegW,
    input  logic       regWriteW,
    output logic       stallF,
    output logic       stallD,
    output logic       flushD,
    output logic       flushE,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       mdBusy,
    output logic       mdDone
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stallCnt,
    output logic [31:0] flushCnt
`endif
);

    logic mdBusyQ;
    logic mdDoneQ;
    logic luStall;
    logic brStall;
    logic mdStall;
    logic anyStall;

    hazard_ctrl_md_seq #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W     (CNT_W)
    ) uMdSeq (
        .clk     (clk),
        .rst     (rst),
        .mdStartE(mdStartE),
        .mdIsDivE(mdIsDivE),
        .mdBusy  (mdBusyQ),
        .mdDone  (mdDoneQ)
    );

    always_comb begin
        luStall   = 1'b0;
        brStall   = 1'b0;
        mdStall   = 1'b0;
        anyStall  = 1'b0;
        stallF    = 1'b0;
        stallD    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        mdBusy    = 1'b0;
        mdDone    = 1'b0;
        // Outputs stay quiet for the whole reset cycle, not just after the edge.
        if (!rst) begin
            if (regHit(regWriteM, writeRegM, rsE))      forwardAE = FWD_MEM;
            else if (regHit(regWriteW, writeRegW, rsE)) forwardAE = FWD_WB;
            if (regHit(regWriteM, writeRegM, rtE))      forwardBE = FWD_MEM;
            else if (regHit(regWriteW, writeRegW, rtE)) forwardBE = FWD_WB;

            forwardAD = regHit(regWriteM, writeRegM, rsD);
            forwardBD = regHit(regWriteM, writeRegM, rtD);

            luStall = memToRegE && (regHit(regWriteE, writeRegE, rsD) ||
                                    regHit(regWriteE, writeRegE, rtD));
            brStall = branchD && (regHit(regWriteE, writeRegE, rsD) ||
                                  regHit(regWriteE, writeRegE, rtD) ||
                                  regHit(memToRegM, writeRegM, rsD) ||
                                  regHit(memToRegM, writeRegM, rtD));
            // DONE still counts as busy: HI/LO only land at the end of that cycle.
            mdStall  = mdBusyQ && (mdReadD || mdOpD);
            anyStall = luStall || brStall || mdStall;

            stallF = anyStall;
            stallD = anyStall;
            flushE = anyStall;
            flushD = takenD && !anyStall;
            mdBusy = mdBusyQ;
            mdDone = mdDoneQ;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stallD && (stallCnt != 32'hFFFF_FFFF)) stallCnt <= stallCnt + 32'd1;
            if (flushD && (flushCnt != 32'hFFFF_FFFF)) flushCnt <= flushCnt + 32'd1;
        end
    end
`endif

endmodule
